// File: rtl/esfa_pkg.sv
// Shared opcodes, cell broadcast selectors and sequencer state encoding
// for the ESFA host-side cell controller.
package esfa_pkg;

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_ENCODE = 2'd2;
  localparam logic [1:0] OP_RANK   = 2'd3;

  localparam logic [7:0] SEL_UPDATE  = 8'd0;
  localparam logic [7:0] SEL_LOOKUP  = 8'd1;
  localparam logic [7:0] SEL_ENCODE  = 8'd2;
  localparam logic [7:0] SEL_CONGRUP = 8'd3;
  localparam logic [7:0] SEL_CONGRDN = 8'd4;
  localparam logic [7:0] SEL_AVAIL   = 8'd5;
  localparam logic [7:0] SEL_ENRANK  = 8'd6;
  localparam logic [7:0] SEL_DEBUG   = 8'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_CAPT   = 3'd2,
    ST_WISSUE = 3'd3,
    ST_WCAPT  = 3'd4
  } state_t;

endpackage

// File: rtl/esfa_prio_enc.sv
// Lowest-index-wins priority encoder over the per-cell match bits; also
// flags when more than one cell responded.
module esfa_prio_enc #(
  parameter int N_CELLS = 8
) (
  input  logic [N_CELLS-1:0] cell_bool,
  output logic               any,
  output logic               multi,
  output logic [7:0]         idx
);

  always_comb begin
    any   = |cell_bool;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi = |(cell_bool & (cell_bool - N_CELLS'(1)));
    idx   = 8'd0;
    for (int k = N_CELLS - 1; k >= 0; k--) begin
      if (cell_bool[k]) idx = 8'(k);
    end
  end

endmodule

// File: rtl/esfa_cell_sequencer.sv
// Host-side ESFA controller: drives the shared cell broadcast bus for one
// request at a time and resolves the per-cell returns into a response.
module esfa_cell_sequencer
  import esfa_pkg::*;
#(
  parameter int N_CELLS = 8,
  parameter int W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [W-1:0]         req_addr,
  input  logic [W-1:0]         req_index,
  input  logic [W-1:0]         req_value,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic                 resp_multi,
  output logic [W-1:0]         resp_handle,
  output logic [W-1:0]         resp_data,
  output logic [W-1:0]         resp_ctx,
  output logic [7:0]           cell_sel,
  output logic [W-1:0]         cell_index,
  output logic [W-1:0]         cell_value,
  output logic [W-1:0]         cell_meta,
  output logic                 cell_is_meta,
  input  logic [N_CELLS-1:0]   cell_bool,
  input  logic [N_CELLS*W-1:0] cell_result,
  input  logic [N_CELLS*W-1:0] cell_context
);

  state_t state, next_state;

  logic [1:0]   op_p0;
  logic [W-1:0] addr_p0;
  logic [W-1:0] index_p0;
  logic [W-1:0] value_p0;
  logic [7:0]   h_p1;

  logic         enc_any;
  logic         enc_multi;
  logic [7:0]   enc_idx;
  logic [W-1:0] enc_res, enc_ctx, h_res, h_ctx;
  logic [N_CELLS-1:0] h_onehot;
  logic         accept;

  esfa_prio_enc #(.N_CELLS(N_CELLS)) u_enc (
    .cell_bool (cell_bool),
    .any       (enc_any),
    .multi     (enc_multi),
    .idx       (enc_idx)
  );

  // Cell-return slices for the encoder winner and for the written handle.
  always_comb begin
    enc_res  = '0;
    enc_ctx  = '0;
    h_res    = '0;
    h_ctx    = '0;
    h_onehot = '0;
    for (int k = 0; k < N_CELLS; k++) begin
      if (8'(k) == enc_idx) begin
        enc_res = cell_result[k*W +: W];
        enc_ctx = cell_context[k*W +: W];
      end
      if (8'(k) == h_p1) begin
        h_res       = cell_result[k*W +: W];
        h_ctx       = cell_context[k*W +: W];
        h_onehot[k] = 1'b1;
      end
    end
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_ISSUE;
      ST_ISSUE:  next_state = ST_CAPT;
      ST_CAPT:   next_state = (op_p0 == OP_INSERT && enc_any) ? ST_WISSUE : ST_IDLE;
      ST_WISSUE: next_state = ST_WCAPT;
      ST_WCAPT:  next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state == ST_IDLE) && !reset;
    cell_sel     = SEL_AVAIL;
    cell_is_meta = 1'b0;
    cell_index   = '0;
    cell_value   = '0;
    cell_meta    = '0;
    case (state)
      ST_ISSUE: begin
        case (op_p0)
          OP_LOOKUP: begin
            cell_sel     = SEL_LOOKUP;
            cell_meta    = addr_p0;
            cell_index   = index_p0;
            cell_is_meta = 1'b1;
          end
          OP_ENCODE: begin
            cell_sel     = SEL_ENCODE;
            cell_meta    = addr_p0;
            cell_is_meta = 1'b1;
          end
          OP_RANK: begin
            cell_sel     = SEL_ENRANK;
            cell_meta    = addr_p0;
            cell_is_meta = 1'b1;
          end
          default: cell_sel = SEL_AVAIL;
        endcase
      end
      ST_WISSUE: begin
        cell_sel     = SEL_UPDATE;
        cell_meta    = W'(h_p1);
        cell_index   = index_p0;
        cell_value   = value_p0;
        cell_is_meta = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage p0: request latch; stage p1: free handle from the INSERT scan.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= req_op;
      addr_p0  <= req_addr;
      index_p0 <= req_index;
      value_p0 <= req_value;
    end
    if (state == ST_CAPT && op_p0 == OP_INSERT && enc_any) h_p1 <= enc_idx;
  end

  // Response register: strobe for one cycle, fields hold until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_multi  <= 1'b0;
      resp_handle <= '0;
      resp_data   <= '0;
      resp_ctx    <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (state == ST_CAPT && op_p0 != OP_INSERT) begin
        resp_valid  <= 1'b1;
        resp_hit    <= enc_any;
        resp_multi  <= enc_multi;
        resp_handle <= enc_any ? W'(enc_idx) : '0;
        resp_data   <= enc_any ? enc_res : '0;
        resp_ctx    <= enc_any ? enc_ctx : '0;
      end else if (state == ST_CAPT && !enc_any) begin
        resp_valid  <= 1'b1;
        resp_hit    <= 1'b0;
        resp_multi  <= 1'b0;
        resp_handle <= '0;
        resp_data   <= '0;
        resp_ctx    <= '0;
      end else if (state == ST_WCAPT) begin
        resp_valid  <= 1'b1;
        resp_hit    <= (cell_bool == h_onehot);
        resp_multi  <= enc_multi;
        resp_handle <= W'(h_p1);
        resp_data   <= h_res;
        resp_ctx    <= h_ctx;
      end
    end
  end

endmodule

// File: tb/tb_esfa_cell_sequencer.sv
// Directed bench for esfa_cell_sequencer with a small behavioural cell-array
// model answering the broadcast bus one cycle later.
module tb_esfa_cell_sequencer;
  localparam int N = 8;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [1:0]     req_op = 2'd0;
  logic [W-1:0]   req_addr = '0, req_index = '0, req_value = '0;
  logic           resp_valid, resp_hit, resp_multi;
  logic [W-1:0]   resp_handle, resp_data, resp_ctx;
  logic [7:0]     cell_sel;
  logic [W-1:0]   cell_index, cell_value, cell_meta;
  logic           cell_is_meta;
  logic [N-1:0]   cell_bool = '0;
  logic [N*W-1:0] cell_result = '0, cell_context = '0;

  int total = 0;
  int bad = 0;

  esfa_cell_sequencer #(.N_CELLS(N), .W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_index(req_index), .req_value(req_value),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_multi(resp_multi),
    .resp_handle(resp_handle), .resp_data(resp_data), .resp_ctx(resp_ctx),
    .cell_sel(cell_sel), .cell_index(cell_index), .cell_value(cell_value),
    .cell_meta(cell_meta), .cell_is_meta(cell_is_meta),
    .cell_bool(cell_bool), .cell_result(cell_result), .cell_context(cell_context)
  );

  // Cell array model: occupancy, array code (= handle written), index, value.
  logic [N-1:0]      occ = '0;
  logic [N-1:0][7:0] code, sidx, sval;
  logic [N-1:0]      force_bool = '0;
  int                wcnt = 0;
  logic [7:0]        w_meta = '0, w_index = '0, w_value = '0;

  always @(posedge clk) begin
    cell_bool    <= '0;
    cell_result  <= '0;
    cell_context <= '0;
    if (cell_sel == 8'd0) begin
      wcnt    <= wcnt + 1;
      w_meta  <= cell_meta;
      w_index <= cell_index;
      w_value <= cell_value;
    end
    case (cell_sel)
      8'd0: if (cell_meta < 8'(N)) begin
        occ[cell_meta[2:0]]  <= 1'b1;
        code[cell_meta[2:0]] <= cell_meta;
        sidx[cell_meta[2:0]] <= cell_index;
        sval[cell_meta[2:0]] <= cell_value;
        cell_bool            <= N'(1) << cell_meta[2:0];
      end
      8'd1: begin
        if (force_bool != '0) begin
          cell_bool <= force_bool;
          for (int k = 0; k < N; k++) begin
            cell_result[k*W +: W]  <= 8'(8'hA0 + k);
            cell_context[k*W +: W] <= 8'(8'hC0 + k);
          end
        end else begin
          for (int k = 0; k < N; k++)
            if (occ[k] && code[k] == cell_meta && sidx[k] == cell_index) begin
              cell_bool[k]           <= 1'b1;
              cell_result[k*W +: W]  <= sval[k];
              cell_context[k*W +: W] <= 8'd1;
            end
        end
      end
      8'd2: for (int k = 0; k < N; k++)
        if (occ[k] && code[k] == cell_meta) begin
          cell_bool[k]          <= 1'b1;
          cell_result[k*W +: W] <= code[k];
        end
      8'd5: cell_bool <= ~occ;
      8'd6: for (int k = 0; k < N; k++)
        if (occ[k] && code[k] == cell_meta) begin
          cell_bool[k]          <= 1'b1;
          cell_result[k*W +: W] <= sidx[k];
        end
      default: ;
    endcase
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] i,
                       input logic [7:0] v, output int lat);
    lat = 0;
    @(negedge clk);
    req_op = op; req_addr = a; req_index = i; req_value = v; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_reset got %b want 0", req_ready); end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got %b want 1", req_ready); end
    @(negedge clk);
    total++; if ({resp_valid, resp_hit, resp_multi, resp_handle, resp_data, resp_ctx} !== '0) begin
      bad++; $display("FAIL rst_resp got v%b h%b m%b %h %h %h want all 0", resp_valid, resp_hit, resp_multi, resp_handle, resp_data, resp_ctx); end
    total++; if ({cell_sel, cell_is_meta, cell_index, cell_value, cell_meta} !== {8'd5, 1'b0, 24'd0}) begin
      bad++; $display("FAIL rst_bcast got sel%0d im%b %h %h %h want sel5 im0 0 0 0", cell_sel, cell_is_meta, cell_index, cell_value, cell_meta); end
  endtask

  task automatic test_insert_first;
    int lat;
    issue(2'd1, 8'h00, 8'd3, 8'h5A, lat);
    total++; if (lat != 5) begin bad++; $display("FAIL ins0_latency got %0d want 5", lat); end
    total++; if ({resp_hit, resp_handle, resp_data} !== {1'b1, 8'd0, 8'd0}) begin
      bad++; $display("FAIL ins0_resp got hit%b h%0d d%h want hit1 h0 d00", resp_hit, resp_handle, resp_data); end
    total++; if (wcnt != 1 || w_meta !== 8'd0 || w_index !== 8'd3 || w_value !== 8'h5A) begin
      bad++; $display("FAIL ins0_write got n%0d meta%h idx%h val%h want n1 meta00 idx03 val5a", wcnt, w_meta, w_index, w_value); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b0 || resp_hit !== 1'b1) begin
      bad++; $display("FAIL ins0_pulse got v%b hit%b want v0 hit1", resp_valid, resp_hit); end
  endtask

  task automatic test_lookup;
    int lat;
    issue(2'd0, 8'h00, 8'd3, 8'h00, lat);
    total++; if (lat != 3) begin bad++; $display("FAIL lk_latency got %0d want 3", lat); end
    total++; if ({resp_hit, resp_multi, resp_handle, resp_data, resp_ctx} !== {2'b10, 8'd0, 8'h5A, 8'd1}) begin
      bad++; $display("FAIL lk_hit got hit%b m%b h%0d d%h c%h want hit1 m0 h0 d5a c01", resp_hit, resp_multi, resp_handle, resp_data, resp_ctx); end
    issue(2'd0, 8'h00, 8'd4, 8'h00, lat);
    total++; if (lat != 3 || resp_hit !== 1'b0) begin bad++; $display("FAIL lk_miss got lat%0d hit%b want lat3 hit0", lat, resp_hit); end
  endtask

  task automatic test_encode_rank;
    int lat;
    issue(2'd1, 8'h00, 8'd7, 8'h11, lat);
    total++; if (lat != 5 || resp_handle !== 8'd1) begin bad++; $display("FAIL ins1 got lat%0d h%0d want lat5 h1", lat, resp_handle); end
    issue(2'd1, 8'h00, 8'd1, 8'h22, lat);
    total++; if (lat != 5 || resp_handle !== 8'd2) begin bad++; $display("FAIL ins2 got lat%0d h%0d want lat5 h2", lat, resp_handle); end
    issue(2'd2, 8'd2, 8'd0, 8'd0, lat);
    total++; if (lat != 3 || {resp_hit, resp_handle, resp_data} !== {1'b1, 8'd2, 8'd2}) begin
      bad++; $display("FAIL enc2 got lat%0d hit%b h%0d d%h want lat3 hit1 h2 d02", lat, resp_hit, resp_handle, resp_data); end
    issue(2'd3, 8'd2, 8'd0, 8'd0, lat);
    total++; if (lat != 3 || {resp_hit, resp_data} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL rank2 got lat%0d hit%b d%h want lat3 hit1 d01", lat, resp_hit, resp_data); end
    issue(2'd2, 8'd9, 8'd0, 8'd0, lat);
    total++; if (lat != 3 || resp_hit !== 1'b0) begin bad++; $display("FAIL enc9 got lat%0d hit%b want lat3 hit0", lat, resp_hit); end
  endtask

  task automatic test_multi;
    int lat;
    force_bool = 8'b0001_0010;
    issue(2'd0, 8'd0, 8'd0, 8'd0, lat);
    force_bool = '0;
    total++; if (lat != 3 || {resp_hit, resp_multi, resp_handle, resp_data, resp_ctx} !== {2'b11, 8'd1, 8'hA1, 8'hC1}) begin
      bad++; $display("FAIL multi got lat%0d hit%b m%b h%0d d%h c%h want lat3 hit1 m1 h1 da1 cc1", lat, resp_hit, resp_multi, resp_handle, resp_data, resp_ctx); end
  endtask

  task automatic test_reset_wissue;
    int w0;
    int seen;
    w0 = wcnt;
    seen = 0;
    @(negedge clk);
    req_op = 2'd1; req_index = 8'd9; req_value = 8'h33; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cell_sel !== 8'd0 || cell_meta !== 8'd3 || cell_is_meta !== 1'b1) begin
      bad++; $display("FAIL rw_wissue got sel%0d meta%h im%b want sel0 meta03 im1", cell_sel, cell_meta, cell_is_meta); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b0 || cell_sel !== 8'd5) begin
      bad++; $display("FAIL rw_in_reset got rdy%b sel%0d want rdy0 sel5", req_ready, cell_sel); end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1 || cell_is_meta !== 1'b0) begin
      bad++; $display("FAIL rw_after got rdy%b im%b want rdy1 im0", req_ready, cell_is_meta); end
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    total++; if (seen != 0 || wcnt != w0 + 1) begin
      bad++; $display("FAIL rw_noresp got resp%0d writes%0d want resp0 writes%0d", seen, wcnt - w0, 1); end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(2'd0, 8'h00, 8'd3, 8'h00, lat);
    total++; if (lat != 3 || req_ready !== 1'b1) begin bad++; $display("FAIL b2b_first got lat%0d rdy%b want lat3 rdy1", lat, req_ready); end
    req_op = 2'd2; req_addr = 8'd1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid) begin lat = c; break; end
    end
    total++; if (lat != 3 || {resp_hit, resp_handle, resp_data} !== {1'b1, 8'd1, 8'd1}) begin
      bad++; $display("FAIL b2b_second got lat%0d hit%b h%0d d%h want lat3 hit1 h1 d01", lat, resp_hit, resp_handle, resp_data); end
  endtask

  task automatic test_full;
    int lat;
    int w0;
    for (int j = 4; j < 8; j++) begin
      issue(2'd1, 8'h00, 8'(j), 8'(j), lat);
      total++; if (lat != 5 || resp_hit !== 1'b1 || resp_handle !== 8'(j)) begin
        bad++; $display("FAIL fill%0d got lat%0d hit%b h%0d want lat5 hit1 h%0d", j, lat, resp_hit, resp_handle, j); end
    end
    w0 = wcnt;
    issue(2'd1, 8'h00, 8'd1, 8'd1, lat);
    total++; if (lat != 3 || {resp_hit, resp_multi, resp_handle, resp_data} !== {2'b00, 8'd0, 8'd0}) begin
      bad++; $display("FAIL full got lat%0d hit%b m%b h%0d d%h want lat3 hit0 m0 h0 d00", lat, resp_hit, resp_multi, resp_handle, resp_data); end
    repeat (3) @(negedge clk);
    total++; if (wcnt != w0) begin bad++; $display("FAIL full_nowrite got %0d writes want 0", wcnt - w0); end
  endtask

  initial begin
    test_reset();
    test_insert_first();
    test_lookup();
    test_encode_rank();
    test_multi();
    test_reset_wissue();
    test_back_to_back();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/esfa_cell_sequencer.md
# esfa_cell_sequencer

- Host-side controller for the ESFA memory-cell array.
- Accepts one high-level request at a time (LOOKUP, INSERT, ENCODE, RANK) over a valid/ready handshake.
- Sequences the broadcast selector/operand bus shared by all cells, then priority-resolves the per-cell `bool`/`result`/`context` returns into a single registered response.
- Sits between the command front-end and the `N_CELLS` cell instances; it is the only driver of the cell broadcast bus.

## Interface

Parameters:
- `N_CELLS`, 8, number of cells; cell handles are 0..`N_CELLS`-1 (≤ 256).
- `W`, 8, data/handle/metadata width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 2: 0 LOOKUP, 1 INSERT, 2 ENCODE, 3 RANK.
- `req_addr` in W: array code (LOOKUP), handle (ENCODE/RANK), unused (INSERT).
- `req_index` in W: element index (LOOKUP/INSERT).
- `req_value` in W: element value (INSERT).
- `resp_valid` out 1: one-cycle response strobe.
- `resp_hit` out 1: operation succeeded / match found.
- `resp_multi` out 1: more than one cell asserted `bool` on the decisive step.
- `resp_handle` out W: winning cell number, zero-extended.
- `resp_data` out W: winning cell result (value / array code / rank / handle).
- `resp_ctx` out W: winning cell context.
- `cell_sel` out 8: broadcast selector.
- `cell_index` out W: broadcast index.
- `cell_value` out W: broadcast value.
- `cell_meta` out W: broadcast metadata.
- `cell_is_meta` out 1: broadcast metadata-valid.
- `cell_bool` in `N_CELLS`: per-cell match bits; bit k is cell k.
- `cell_result` in `N_CELLS`·W: cell k's result at bits [k·W +: W].
- `cell_context` in `N_CELLS`·W: same packing as `cell_result`.

## Operation

- FSM states: IDLE, ISSUE, CAPT, WISSUE, WCAPT.
- Idle broadcast, driven in IDLE, CAPT and WCAPT: `sel`=5 (markAvailable, read-only), `is_meta`=0, `index`/`value`/`meta`=0. Cell state is written only while `sel` ∈ {0, 3, 4}; the idle value never mutates cells.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `op`/`addr`/`index`/`value` and go to ISSUE.
- ISSUE drives one broadcast for one cycle:
  - LOOKUP: `sel`=1, `meta`=`addr`, `index`=`index`, `is_meta`=1.
  - ENCODE: `sel`=2, `meta`=`addr`, `is_meta`=1.
  - RANK: `sel`=6, `meta`=`addr`, `is_meta`=1.
  - INSERT: `sel`=5, `is_meta`=0.
- ISSUE → CAPT unconditionally.
- CAPT samples `cell_*`, which hold the ISSUE-cycle results, through the priority encoder (lowest cell number wins).
  - Non-INSERT: register the response and go to IDLE.
  - INSERT with no free cell: response with `resp_hit`=0, `resp_handle`=0, `resp_data`=0, then IDLE.
  - INSERT with a free cell: latch free handle h and go to WISSUE.
- WISSUE: drive `sel`=0, `meta`=h, `is_meta`=1, `index`=`index`, `value`=`value` for exactly one cycle. → WCAPT.
- WCAPT: `resp_hit` = (`cell_bool` == one-hot(h)); `resp_handle`=h; `resp_data`=`cell_result`[h]; `resp_ctx`=`cell_context`[h]. → IDLE.
- `resp_multi` = popcount(`cell_bool`) > 1 on the sampled step. It is ignored for the INSERT free scan.
- Arithmetic: handle = encoder index, zero-extended to W. No other arithmetic is performed.

## Timing

- Reset values: `req_ready`=0 during reset and 1 in the first cycle after; `resp_*`=0; broadcast at idle values; state IDLE.
- Reset asserted in any state aborts the operation: no response, no further broadcast. A write already issued in WISSUE is not undone.
- Acceptance is at edge 0.
  - LOOKUP/ENCODE/RANK: ISSUE in cycle 1, CAPT in cycle 2, `resp_valid` high in cycle 3.
  - INSERT (success): `resp_valid` in cycle 5.
  - INSERT (full): `resp_valid` in cycle 3.
- `resp_valid` is a single-cycle pulse with no backpressure. It coincides with IDLE and `req_ready`=1, so a new request may be accepted in the same cycle as the response.
- `req_ready`=0 in ISSUE, CAPT, WISSUE and WCAPT. `req_valid` is ignored there.
- `resp_*` data fields hold their value until the next response or reset.

## Structure

- Package `esfa_pkg`:
  - opcode constants: `OP_LOOKUP`/`OP_INSERT`/`OP_ENCODE`/`OP_RANK`;
  - cell selector constants: `SEL_UPDATE`=0, `SEL_LOOKUP`=1, `SEL_ENCODE`=2, `SEL_CONGRUP`=3, `SEL_CONGRDN`=4, `SEL_AVAIL`=5, `SEL_ENRANK`=6, `SEL_DEBUG`=7;
  - FSM state encoding.
- Sub-module `esfa_prio_enc`, parameterised by `N_CELLS`:
  - combinational, input `cell_bool`;
  - outputs `any`, `multi`, `idx` (lowest set bit).
  - Used for both the read-path select and the free-cell search.

## Test plan

- Reset, then INSERT(`index`=3, `value`=0x5A) on an empty array → free scan picks handle 0; WISSUE broadcast is `sel`=0, `meta`=0; `resp_valid` in cycle 5 with `hit`=1, `handle`=0, `data`=0.
- Then LOOKUP(`addr`=0, `index`=3) → `resp_valid` in cycle 3 with `hit`=1, `handle`=0, `data`=0x5A, `ctx`=1. LOOKUP(`addr`=0, `index`=4) → `hit`=0.
- Fill all 8 cells with INSERT; 9th INSERT → `resp_valid` in cycle 3 with `hit`=0, and no `sel`=0 ever broadcast.
- ENCODE(`addr`=2) after inserting into handle 2 → `hit`=1, `data`=2. RANK(`addr`=2) → `data`=1. ENCODE(`addr`=9) → `hit`=0.
- Cell model forcing two `bool` bits (cells 1 and 4) on LOOKUP → `handle`=1, `resp_multi`=1.
- Assert `reset` in WISSUE → no `resp_valid`, `req_ready`=1 the cycle after reset deasserts, broadcast at idle values; back-to-back request accepted on the response cycle.
